// File: rtl/cic_decim_echip65.sv
// Nth-order CIC decimator for a 1-bit sigma-delta bitstream, runtime power-of-two ratio.
// Define CIC_DEBUG_MON_EN to add the registered mon_sel/mon_out debug monitor.
`timescale 1ns/1ps
module cic_decim_echip65 #(
    parameter int unsigned ORDER     = 3,
    parameter int unsigned MAX_DECIM = 256,
    parameter int unsigned LOG_W     = $clog2($clog2(MAX_DECIM) + 1),
    parameter int unsigned ACC_W     = ORDER * $clog2(MAX_DECIM) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             in,
    input  logic [LOG_W-1:0] decim_log2,
`ifdef CIC_DEBUG_MON_EN
    input  logic [3:0]       mon_sel,
    output logic [ACC_W-1:0] mon_out,
`endif
    output logic [ACC_W-1:0] out,
    output logic             out_valid,
    output logic             cfg_err
);

    localparam int unsigned LMAX  = $clog2(MAX_DECIM);
    localparam int unsigned CNT_W = LMAX;
    localparam int unsigned SET_W = $clog2(ORDER + 1);

    logic [ACC_W-1:0] acc    [ORDER];
    logic [ACC_W-1:0] dly    [ORDER];
    logic [ACC_W-1:0] diff_c [ORDER];
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_last_c;
    logic [LOG_W-1:0] ratio;
    logic [SET_W-1:0] settle;
    logic             en_d;
    logic             frame_start_c;
    logic             comb_tick_c;
    logic             legal_c;
    logic             ratio_chg_c;
    logic             reload_c;
    int unsigned      shamt_c;
    logic [ACC_W-1:0] out_c;

    // Frame control, comb differences and gain-normalised output value
    always_comb begin
        logic [ACC_W-1:0] d;
        cnt_last_c    = CNT_W'((32'd1 << ratio) - 32'd1);
        frame_start_c = en && (cnt == '0);
        comb_tick_c   = en && (cnt == cnt_last_c);
        legal_c       = (decim_log2 != '0) && (decim_log2 <= LOG_W'(LMAX));
        ratio_chg_c   = frame_start_c && legal_c && (decim_log2 != ratio);
        reload_c      = (en && !en_d) || ratio_chg_c;
        d             = acc[ORDER-1] - dly[0];
        diff_c[0]     = d;
        for (int unsigned k = 1; k < ORDER; k++) begin
            d         = d - dly[k];
            diff_c[k] = d;
        end
        shamt_c = ORDER * (LMAX - 32'(ratio));
        out_c   = d << shamt_c;
    end

    // Integrator cascade and comb delay line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < ORDER; k++) begin
                acc[k] <= '0;
                dly[k] <= '0;
            end
        end else if (en) begin
            acc[0] <= acc[0] + ACC_W'(in);
            for (int unsigned k = 1; k < ORDER; k++)
                acc[k] <= acc[k] + acc[k-1];
            if (comb_tick_c) begin
                dly[0] <= acc[ORDER-1];
                for (int unsigned k = 1; k < ORDER; k++)
                    dly[k] <= diff_c[k-1];
            end
        end
    end

    // Frame counter, ratio latch, settle suppression and output register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            ratio     <= LOG_W'(LMAX);
            cfg_err   <= 1'b0;
            settle    <= SET_W'(ORDER);
            en_d      <= 1'b0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            en_d      <= en;
            out_valid <= 1'b0;
            if (!en || comb_tick_c)
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);
            if (frame_start_c) begin
                if (legal_c) begin
                    ratio   <= decim_log2;
                    cfg_err <= 1'b0;
                end else begin
                    cfg_err <= 1'b1;
                end
            end
            if (reload_c)
                settle <= SET_W'(ORDER);
            else if (comb_tick_c && (settle != '0))
                settle <= settle - SET_W'(1);
            if (comb_tick_c && (settle == '0)) begin
                out       <= out_c;
                out_valid <= 1'b1;
            end
        end
    end

`ifdef CIC_DEBUG_MON_EN
    logic [ACC_W-1:0] diff_q [ORDER];
    logic [ACC_W-1:0] mon_c;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned k = 0; k < ORDER; k++)
                diff_q[k] <= '0;
        end else if (comb_tick_c) begin
            for (int unsigned k = 0; k < ORDER; k++)
                diff_q[k] <= diff_c[k];
        end
    end

    // Debug source select
    always_comb begin
        mon_c = '0;
        if (mon_sel == 4'd0)
            mon_c = out;
        else if (mon_sel == 4'd14)
            mon_c = ACC_W'(cnt);
        else if (mon_sel == 4'd15)
            mon_c = '1;
        for (int unsigned k = 0; k < ORDER; k++) begin
            if (mon_sel == 4'(k + 1))
                mon_c = acc[k];
            if (mon_sel == 4'(k + 6))
                mon_c = diff_q[k];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            mon_out <= '0;
        else
            mon_out <= mon_c;
    end
`endif

endmodule

// File: tb/tb_cic_decim_echip65.sv
// Self-checking bench for cic_decim_echip65: vector table, corner sequences and
// randomized stimulus against a frame-level CIC reference model.
`timescale 1ns/1ps
module tb_cic_decim_echip65;

    localparam int N  = 3;
    localparam int LM = 8;
    localparam int AW = N * LM + 1;
    localparam longint MASK = (64'sd1 <<< AW) - 1;
    localparam longint FULL = 64'sd16777216;
    localparam longint HALF = 64'sd8388608;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          in_b = 1'b0;
    logic [3:0]    decim_log2 = 4'd8;
    logic [AW-1:0] out;
    logic          out_valid;
    logic          cfg_err;

    int n_checks = 0;
    int n_err    = 0;

    cic_decim_echip65 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .in        (in_b),
        .decim_log2(decim_log2),
        .out       (out),
        .out_valid (out_valid),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: integrator sums, tick history of the last integrator,
    // Nth-order finite difference via binomial weights.
    longint m_acc [N];
    longint hist [$];
    int     m_pos, m_ratio, m_settle;
    bit     m_en_prev, m_valid, m_cfg;
    longint m_out;

    function automatic longint binom(int n, int k);
        longint r = 1;
        for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < N; k++) m_acc[k] = 0;
        hist.delete();
        for (int k = 0; k < N; k++) hist.push_back(0);
        m_pos = 0; m_ratio = LM; m_settle = N;
        m_en_prev = 0; m_valid = 0; m_cfg = 0; m_out = 0;
    endtask

    task automatic model_cycle(input bit e, input bit b, input int d);
        longint y;
        m_valid = 0;
        if (!e) begin
            m_pos = 0;
            m_en_prev = 0;
            return;
        end
        if (!m_en_prev) m_settle = N;
        if (m_pos == 0) begin
            if (d >= 1 && d <= LM) begin
                if (d != m_ratio) m_settle = N;
                m_ratio = d;
                m_cfg = 0;
            end else begin
                m_cfg = 1;
            end
        end
        if (m_pos == (1 << m_ratio) - 1) begin
            hist.push_back(m_acc[N-1]);
            y = 0;
            for (int j = 0; j <= N; j++) begin
                if (j % 2 == 1) y = y - binom(N, j) * hist[hist.size() - 1 - j];
                else            y = y + binom(N, j) * hist[hist.size() - 1 - j];
            end
            void'(hist.pop_front());
            y = y & MASK;
            if (m_settle > 0) m_settle--;
            else begin
                m_out = (y <<< (N * (LM - m_ratio))) & MASK;
                m_valid = 1;
            end
            m_pos = 0;
        end else begin
            m_pos++;
        end
        for (int k = N - 1; k >= 1; k--) m_acc[k] = (m_acc[k] + m_acc[k-1]) & MASK;
        m_acc[0] = (m_acc[0] + longint'(b)) & MASK;
        m_en_prev = 1;
    endtask

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic step();
        model_cycle(en, in_b, int'(decim_log2));
        @(posedge clk);
        #1;
        chk("out", 64'(out), m_out);
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("cfg_err", 64'(cfg_err), 64'(m_cfg));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        en = 1'b0;
        in_b = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset_out", 64'(out), 0);
        chk("reset_valid", 64'(out_valid), 0);
        chk("reset_cfg_err", 64'(cfg_err), 0);
        reset_n = 1'b1;
    endtask

    task automatic wait_strobe(input int budget, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!out_valid && n < budget);
        if (!out_valid) begin
            n_checks++;
            n_err++;
            $display("FAIL strobe_timeout: no out_valid within %0d cycles", n);
            n = -1;
        end
    endtask

    typedef struct {
        int     dl;
        int     pat;      // 0 zeros, 1 ones, 2 alternating
        int     frames;
        longint exp_out;
        int     exp_strobes;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n, r, strobes;
        longint last;

        vecs[0] = '{8, 1, 6,  FULL, 3};
        vecs[1] = '{8, 0, 5,  0,    2};
        vecs[2] = '{8, 2, 6,  HALF, 3};
        vecs[3] = '{4, 1, 10, FULL, 7};
        vecs[4] = '{1, 1, 12, FULL, 9};
        vecs[5] = '{1, 2, 12, HALF, 9};
        vecs[6] = '{6, 2, 8,  HALF, 5};
        vecs[7] = '{5, 1, 8,  FULL, 5};

        for (int i = 0; i < 8; i++) begin
            do_reset();
            decim_log2 = 4'(vecs[i].dl);
            en = 1'b1;
            r = 1 << vecs[i].dl;
            strobes = 0;
            last = -1;
            for (int c = 0; c < vecs[i].frames * r; c++) begin
                case (vecs[i].pat)
                    0:       in_b = 1'b0;
                    1:       in_b = 1'b1;
                    default: in_b = (c % 2 == 0);
                endcase
                step();
                if (out_valid) begin
                    strobes++;
                    last = longint'(out);
                end
            end
            chk("row_out", 64'(last), 64'(vecs[i].exp_out));
            chk("row_strobes", 64'(strobes), 64'(vecs[i].exp_strobes));
        end

        // Settling at R=256 and steady strobe period
        do_reset();
        decim_log2 = 4'd8; en = 1'b1; in_b = 1'b1;
        wait_strobe(2000, n); chk("first_strobe_r256", 64'(n), 1024);
        wait_strobe(400, n);  chk("period_r256", 64'(n), 256);
        chk("full_scale_r256", 64'(out), FULL);

        // Ratio change mid-frame takes effect at the next frame start
        for (int c = 0; c < 100; c++) step();
        decim_log2 = 4'd4;
        wait_strobe(400, n); chk("old_frame_end", 64'(n), 156);
        wait_strobe(400, n); chk("settle_after_switch", 64'(n), 64);
        wait_strobe(100, n); chk("period_r16", 64'(n), 16);
        chk("full_scale_r16", 64'(out), FULL);

        // Illegal ratio holds 256 and flags cfg_err until a legal sample
        decim_log2 = 4'd8;
        wait_strobe(2000, n); chk("settle_back_r256", 64'(n), 1024);
        decim_log2 = 4'd0;
        wait_strobe(400, n); chk("illegal_hold_period", 64'(n), 256);
        chk("cfg_err_set", 64'(cfg_err), 1);
        decim_log2 = 4'd8;
        wait_strobe(400, n); chk("legal_no_resettle", 64'(n), 256);
        chk("cfg_err_clear", 64'(cfg_err), 0);

        // en low mid-frame: hold, no strobes; resume restarts and resettles
        decim_log2 = 4'd4;
        wait_strobe(400, n); chk("switch_r16_again", 64'(n), 64);
        for (int c = 0; c < 5; c++) step();
        en = 1'b0;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            if (out_valid) strobes++;
        end
        chk("en_low_no_strobe", 64'(strobes), 0);
        en = 1'b1;
        wait_strobe(200, n); chk("en_resume_settle", 64'(n), 64);

        // en dropping on the tick cycle discards the tick
        n = 0;
        while (m_pos != (1 << m_ratio) - 1 && n < 40) begin
            step();
            n++;
        end
        en = 1'b0;
        step();
        chk("tick_discarded", 64'(out_valid), 0);
        en = 1'b1;
        wait_strobe(200, n); chk("after_discard_settle", 64'(n), 64);

        // Asynchronous reset mid-frame clears outputs at once
        for (int c = 0; c < 7; c++) step();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_out", 64'(out), 0);
        chk("async_rst_valid", 64'(out_valid), 0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;
        wait_strobe(200, n); chk("post_reset_first", 64'(n), 64);

        // Randomized traffic with ratio changes (some illegal) and en gaps
        decim_log2 = 4'd2;
        for (int c = 0; c < 3000; c++) begin
            in_b = 1'($urandom % 2);
            en = ($urandom % 300) != 0;
            if ($urandom % 150 == 0) begin
                if ($urandom % 4 == 0) decim_log2 = 4'($urandom_range(0, 15));
                else                   decim_log2 = 4'($urandom_range(1, 5));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
